// File: rtl/fft_pkg.sv
// Shared helpers for the FFT output reorder block: address bit reversal,
// a constant-foldable log2, and the packed complex sample layout.
package fft_pkg;

    // A complex sample is stored packed as {re, im}: the real part occupies the
    // upper WIDTH bits and the imaginary part the lower WIDTH bits.
    localparam int CPLX_PARTS = 2;

    // Ceiling log2 for elaboration-time sizing where $clog2 is unavailable.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Reverse the low nbits of value; bits above nbits come back as zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int nbits);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < nbits) begin
                result[nbits - 1 - i] = value[i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/reorder_pingpong_ram.sv
// Two-bank sample store for the reorder block. One synchronous write port,
// one combinational-address read port; the caller registers the read data.
// Contents are deliberately not reset.
module reorder_pingpong_ram
    import fft_pkg::*;
#(
    parameter int N      = 64,
    parameter int DATA_W = 16,
    parameter int ADDR_W = clog2(N)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_wr_bank,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_bank,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    // Bank select is the top address bit, so both banks live in one array.
    logic [DATA_W-1:0] r_mem [0:2*N-1];

    logic [ADDR_W:0] w_wr_index;
    logic [ADDR_W:0] w_rd_index;

    assign w_wr_index = {i_wr_bank, i_wr_addr};
    assign w_rd_index = {i_rd_bank, i_rd_addr};

    // Capture one packed sample per enabled cycle into the filling bank.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[w_wr_index] <= i_wr_data;
        end
    end

    // A sample written on one edge is visible to the read on the next edge,
    // which the reader relies on when it starts immediately after a frame.
    assign o_rd_data = r_mem[w_rd_index];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders one N-point frame of bit-reversed complex samples into natural
// order. A frame fills one bank while the previous frame drains from the
// other, so back-to-back frames stream out at one sample per clock.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int N      = 64,
    parameter int WIDTH  = 8,
    parameter int BITREV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_in,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             enable_out,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im
);

    localparam int LOGN   = clog2(N);
    localparam int DATA_W = CPLX_PARTS * WIDTH;
    localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

    // Write side
    logic [LOGN-1:0]   r_wr_cnt;
    logic              r_wr_bank;
    // Read side
    logic [LOGN-1:0]   r_rd_cnt;
    logic              r_rd_bank;
    logic              r_rd_active;
    // Registered outputs
    logic              r_enable_out;
    logic [WIDTH-1:0]  r_out_re;
    logic [WIDTH-1:0]  r_out_im;

    logic              w_frame_done;
    logic              w_rd_last;
    logic [LOGN-1:0]   w_rd_addr;
    logic [31:0]       w_rd_cnt_rev;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_rd_data;

    // The last sample of a frame lands this edge.
    assign w_frame_done = enable_in && (r_wr_cnt == LAST_IDX);
    assign w_rd_last    = (r_rd_cnt == LAST_IDX);

    assign w_wr_data    = {in_re, in_im};
    assign w_rd_cnt_rev = bit_reverse(32'(r_rd_cnt), LOGN);

    // Natural output index k is stored at bit-reversed address rev(k);
    // with BITREV=0 the block is a plain one-frame delay.
    generate
        if (BITREV != 0) begin : g_bitrev
            assign w_rd_addr = w_rd_cnt_rev[LOGN-1:0];
        end else begin : g_natural
            assign w_rd_addr = r_rd_cnt;
        end
    endgenerate

    reorder_pingpong_ram #(
        .N      (N),
        .DATA_W (DATA_W),
        .ADDR_W (LOGN)
    ) u_ram (
        .clk       (clk),
        .i_we      (enable_in),
        .i_wr_bank (r_wr_bank),
        .i_wr_addr (r_wr_cnt),
        .i_wr_data (w_wr_data),
        .i_rd_bank (r_rd_bank),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // Write counter and bank toggle; a dropped enable restarts the frame in
    // the same bank at address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
        end else if (enable_in) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_frame_done) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end else begin
            r_wr_cnt <= '0;
        end
    end

    // Reader: drain the completed bank in output order. A newly completed
    // frame always wins, which both chains frames without a gap and drops
    // the tail of a frame that is overtaken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cnt     <= '0;
            r_rd_bank    <= 1'b0;
            r_rd_active  <= 1'b0;
            r_enable_out <= 1'b0;
            r_out_re     <= '0;
            r_out_im     <= '0;
        end else begin
            if (r_rd_active) begin
                r_out_re     <= w_rd_data[DATA_W-1:WIDTH];
                r_out_im     <= w_rd_data[WIDTH-1:0];
                r_enable_out <= 1'b1;
                r_rd_cnt     <= r_rd_cnt + 1'b1;
                if (w_rd_last) begin
                    r_rd_active <= 1'b0;
                end
            end else begin
                r_enable_out <= 1'b0;
            end

            if (w_frame_done) begin
                r_rd_bank   <= r_wr_bank;
                r_rd_cnt    <= '0;
                r_rd_active <= 1'b1;
            end
        end
    end

    assign enable_out = r_enable_out;
    assign out_re     = r_out_re;
    assign out_im     = r_out_im;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench: stimulus pushes expected samples, per-instance monitors
// pop and compare whenever enable_out is high.
module tb_fft_bitrev_reorder;

    typedef struct {
        logic [7:0] re;
        logic [7:0] im;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // N=8 bit-reversing instance
    logic       en8 = 1'b0;
    logic [7:0] re8 = '0;
    logic [7:0] im8 = '0;
    logic       en_out8;
    logic [7:0] out_re8;
    logic [7:0] out_im8;

    // N=64 natural-order instance
    logic       en64 = 1'b0;
    logic [7:0] re64 = '0;
    logic [7:0] im64 = '0;
    logic       en_out64;
    logic [7:0] out_re64;
    logic [7:0] out_im64;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t q8[$];
    exp_t q64[$];
    int   n_out8 = 0;
    int   n_out64 = 0;
    int   run8 = 0;
    int   last_run8 = 0;
    int   rise_cyc8 = 0;
    int   rise_cyc64 = 0;
    logic prev_en8 = 1'b0;
    logic prev_en64 = 1'b0;

    // Natural output k of an 8-point frame is input number BR8[k].
    int BR8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_bitrev_reorder #(.N(8), .WIDTH(8), .BITREV(1)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .enable_in  (en8),
        .in_re      (re8),
        .in_im      (im8),
        .enable_out (en_out8),
        .out_re     (out_re8),
        .out_im     (out_im8)
    );

    fft_bitrev_reorder #(.N(64), .WIDTH(8), .BITREV(0)) dut64 (
        .clk        (clk),
        .rst        (rst),
        .enable_in  (en64),
        .in_re      (re64),
        .in_im      (im64),
        .enable_out (en_out64),
        .out_re     (out_re64),
        .out_im     (out_im64)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for the N=8 instance
    always @(negedge clk) begin
        if (en_out8 && !prev_en8) rise_cyc8 = cyc;
        prev_en8 = en_out8;
        if (en_out8) begin
            run8 = run8 + 1;
            checks = checks + 1;
            if (q8.size() == 0) begin
                errors = errors + 1;
                $display("FAIL u8_unexpected: got re=%0d im=%0d, required no output", out_re8, out_im8);
            end else begin
                exp_t e;
                e = q8.pop_front();
                if (out_re8 !== e.re || out_im8 !== e.im) begin
                    errors = errors + 1;
                    $display("FAIL u8_sample %0d: got re=%0d im=%0d, required re=%0d im=%0d",
                             n_out8, out_re8, out_im8, e.re, e.im);
                end else begin
                    $display("u8 sample %0d re=%0d im=%0d ok", n_out8, out_re8, out_im8);
                end
            end
            n_out8 = n_out8 + 1;
        end else if (run8 > 0) begin
            last_run8 = run8;
            run8 = 0;
        end
    end

    // Monitor for the N=64 instance
    always @(negedge clk) begin
        if (en_out64 && !prev_en64) rise_cyc64 = cyc;
        prev_en64 = en_out64;
        if (en_out64) begin
            checks = checks + 1;
            if (q64.size() == 0) begin
                errors = errors + 1;
                $display("FAIL u64_unexpected: got re=%0d im=%0d, required no output", out_re64, out_im64);
            end else begin
                exp_t e;
                e = q64.pop_front();
                if (out_re64 !== e.re || out_im64 !== e.im) begin
                    errors = errors + 1;
                    $display("FAIL u64_sample %0d: got re=%0h im=%0d, required re=%0h im=%0d",
                             n_out64, out_re64, out_im64, e.re, e.im);
                end else begin
                    $display("u64 sample %0d re=%0h im=%0d ok", n_out64, out_re64, out_im64);
                end
            end
            n_out64 = n_out64 + 1;
        end
    end

    task automatic send8(input int r, input int i);
        @(negedge clk);
        en8 = 1'b1;
        re8 = 8'(r);
        im8 = 8'(i);
    endtask

    task automatic idle8(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            en8 = 1'b0;
        end
    endtask

    task automatic push_frame8(input int base_re, input int base_im);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.re = 8'(base_re + BR8[k]);
            e.im = 8'(base_im + BR8[k]);
            q8.push_back(e);
        end
    endtask

    task automatic check_val(input string name, input int got, input int req);
        checks = checks + 1;
        if (got != req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end else begin
            $display("%s = %0d ok", name, got);
        end
    endtask

    // Bounded wait for a scoreboard queue to empty.
    task automatic wait_drain(input string name, input bit use64);
        int c;
        c = 0;
        while (c < 300 && (use64 ? q64.size() : q8.size()) != 0) begin
            @(negedge clk);
            #1;
            c++;
        end
        check_val(name, use64 ? q64.size() : q8.size(), 0);
    endtask

    initial begin
        int last_drive;
        int base;
        int c;
        exp_t e;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_enable_out", int'(en_out8), 0);
        check_val("rst_out_re", int'(out_re8), 0);
        check_val("rst_out_im", int'(out_im8), 0);
        check_val("rst_enable_out64", int'(en_out64), 0);
        rst = 1'b0;
        idle8(2);

        // Single frame, bit-reversed readout, then idle hold
        for (int i = 0; i < 8; i++) send8(i, 10 + i);
        last_drive = cyc;
        push_frame8(0, 10);
        idle8(1);
        wait_drain("t1_drain", 1'b0);
        // Drive at negedge cyc=P, capture at edge P+1, first output after edge P+2.
        check_val("t1_latency", rise_cyc8 - last_drive, 2);
        idle8(12);
        check_val("t6_idle_enable_out", int'(en_out8), 0);
        check_val("t6_hold_re", int'(out_re8), 7);
        check_val("t6_hold_im", int'(out_im8), 17);
        check_val("t6_run_len", last_run8, 8);

        // Three back-to-back frames must stream gaplessly
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) send8(8 * f + i, 100 + 8 * f + i);
            push_frame8(8 * f, 100 + 8 * f);
        end
        idle8(1);
        wait_drain("t2_drain", 1'b0);
        idle8(3);
        check_val("t2_run_len", last_run8, 24);

        // Aborted partial frame followed by a full frame
        base = n_out8;
        for (int i = 0; i < 5; i++) send8(i, 200 + i);
        idle8(1);
        for (int i = 0; i < 8; i++) send8(20 + i, 50 + i);
        push_frame8(20, 50);
        idle8(1);
        wait_drain("t3_drain", 1'b0);
        idle8(10);
        check_val("t3_out_count", n_out8 - base, 8);

        // N=64 natural-order pass-through
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            en64 = 1'b1;
            re64 = (i % 2 == 0) ? 8'h80 : 8'h7F;
            im64 = 8'(i);
            e.re = re64;
            e.im = im64;
            q64.push_back(e);
        end
        last_drive = cyc;
        @(negedge clk);
        en64 = 1'b0;
        wait_drain("t5_drain", 1'b1);
        check_val("t5_latency", rise_cyc64 - last_drive, 2);
        check_val("t5_out_count", n_out64, 64);

        // Asynchronous reset in the middle of a readout
        base = n_out8;
        for (int i = 0; i < 8; i++) send8(40 + i, 70 + i);
        push_frame8(40, 70);
        idle8(1);
        c = 0;
        while (c < 50 && n_out8 < base + 3) begin
            @(negedge clk);
            #1;
            c++;
        end
        check_val("t4_reached_out3", int'(n_out8 >= base + 3), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("t4_async_enable_out", int'(en_out8), 0);
        check_val("t4_async_out_re", int'(out_re8), 0);
        check_val("t4_async_out_im", int'(out_im8), 0);
        q8.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle8(2);
        base = n_out8;
        for (int i = 0; i < 8; i++) send8(30 + i, 60 + i);
        push_frame8(30, 60);
        idle8(1);
        wait_drain("t4_drain", 1'b0);
        idle8(10);
        check_val("t4_out_count", n_out8 - base, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "timeout");
    end

endmodule
